// File: rtl/game_sequencer.sv
// game_sequencer: IDLE/PLAY/OVER game-flow controller. It schedules LFSR-chosen lane spawns and tracks score, difficulty and lives.
// Optional build macro SEQ_NO_REPEAT_EN: consecutive spawns never land in the same lane.
module game_sequencer #(
  parameter int          BASE_INTERVAL = 16,
  parameter int          INTERVAL_STEP = 2,
  parameter int          MIN_INTERVAL  = 4,
  parameter int          PTS_PER_LEVEL = 10,
  parameter int          MAX_DIFF      = 7,
  parameter int          START_LIVES   = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_hit_valid,
  input  logic        i_hit_good,
  output logic        o_spawn_valid,
  output logic [1:0]  o_spawn_lane,
  output logic [1:0]  o_state,
  output logic [13:0] o_score,
  output logic [3:0]  o_diff,
  output logic [2:0]  o_lives
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [7:0]  BASE8      = 8'(BASE_INTERVAL);
  localparam logic [7:0]  STEP8      = 8'(INTERVAL_STEP);
  localparam logic [7:0]  MIN8       = 8'(MIN_INTERVAL);
  localparam logic [7:0]  PTS8       = 8'(PTS_PER_LEVEL);
  localparam logic [3:0]  DIFF_MAX   = 4'(MAX_DIFF);
  localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
  localparam logic [13:0] SCORE_MAX  = 14'd9999;

  state_t       state_reg, state_next;
  logic         start_q_reg;
  logic         spawn_valid_reg;
  logic [1:0]   spawn_lane_reg;
  logic [13:0]  score_reg;
  logic [3:0]   diff_reg;
  logic [2:0]   lives_reg;
  logic [7:0]   cnt_reg;
  logic [7:0]   level_reg;
  logic [15:0]  lfsr_reg;
`ifdef SEQ_NO_REPEAT_EN
  logic [1:0]   prev_lane_reg;
`endif

  logic         start_rise;
  logic         in_play;
  logic         play_entry;
  logic         good_hit;
  logic         miss;
  logic         last_life;
  logic         spawn_due;
  logic         spawn_fire;
  logic [7:0]   step_total;
  logic [7:0]   interval;
  logic [15:0]  lfsr_next;
  logic [1:0]   lane_sel;

  assign start_rise = i_start & ~start_q_reg;
  assign in_play    = (state_reg == ST_PLAY);
  assign play_entry = (state_reg == ST_IDLE) & start_rise;
  assign good_hit   = in_play & i_hit_valid & i_hit_good;
  assign miss       = in_play & i_hit_valid & ~i_hit_good;
  assign last_life  = miss & (lives_reg == 3'd1);

  // Interval in 8 bits, clamped so the subtraction can never wrap below the floor.
  always_comb begin
    step_total = STEP8 * {4'd0, diff_reg};
    if ((step_total < BASE8) && ((BASE8 - step_total) > MIN8))
      interval = BASE8 - step_total;
    else
      interval = MIN8;
  end

  // >= rather than == so a running count already past a freshly shortened interval fires at once instead of wrapping.
  assign spawn_due  = in_play & i_tick & ((cnt_reg + 8'd1) >= interval);
  assign spawn_fire = spawn_due & ~last_life;
  assign lfsr_next  = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  always_comb begin
`ifdef SEQ_NO_REPEAT_EN
    if (lfsr_next[1:0] == prev_lane_reg)
      lane_sel = lfsr_next[1:0] + 2'd1;
    else
      lane_sel = lfsr_next[1:0];
`else
    lane_sel = lfsr_next[1:0];
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_rise) state_next = ST_PLAY;
      ST_PLAY: if (last_life)  state_next = ST_OVER;
      ST_OVER: if (start_rise) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_state       = state_reg;
    o_spawn_valid = spawn_valid_reg;
    o_spawn_lane  = spawn_lane_reg;
    o_score       = score_reg;
    o_diff        = diff_reg;
    o_lives       = lives_reg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_q_reg     <= 1'b1;
      spawn_valid_reg <= 1'b0;
      spawn_lane_reg  <= 2'd0;
      score_reg       <= 14'd0;
      diff_reg        <= 4'd0;
      lives_reg       <= LIVES_INIT;
      cnt_reg         <= 8'd0;
      level_reg       <= 8'd0;
      lfsr_reg        <= LFSR_SEED;
`ifdef SEQ_NO_REPEAT_EN
      prev_lane_reg   <= 2'd0;
`endif
    end else begin
      start_q_reg     <= i_start;
      spawn_valid_reg <= spawn_fire;
      if (play_entry) begin
        score_reg <= 14'd0;
        diff_reg  <= 4'd0;
        level_reg <= 8'd0;
        lives_reg <= LIVES_INIT;
        cnt_reg   <= 8'd0;
`ifdef SEQ_NO_REPEAT_EN
        prev_lane_reg <= 2'd0;
`endif
      end else if (in_play) begin
        if (i_tick)
          cnt_reg <= spawn_due ? 8'd0 : cnt_reg + 8'd1;
        if (spawn_fire) begin
          lfsr_reg       <= lfsr_next;
          spawn_lane_reg <= lane_sel;
`ifdef SEQ_NO_REPEAT_EN
          prev_lane_reg  <= lane_sel;
`endif
        end
        if (good_hit) begin
          if (score_reg < SCORE_MAX)
            score_reg <= score_reg + 14'd1;
          if ((level_reg + 8'd1) == PTS8) begin
            level_reg <= 8'd0;
            if (diff_reg < DIFF_MAX)
              diff_reg <= diff_reg + 4'd1;
          end else begin
            level_reg <= level_reg + 8'd1;
          end
        end
        if (miss)
          lives_reg <= lives_reg - 3'd1;
      end else begin
        cnt_reg <= 8'd0;
      end
    end
  end

endmodule
